// File: rtl/selftrigger_readout_arbiter_pkg.sv
// Shared types and default sizes for the self-trigger readout arbiter.
package selftrigger_readout_arbiter_pkg;
    localparam int DEF_NUM_CH    = 8;
    localparam int DEF_TS_W      = 64;
    localparam int DEF_HOLDOFF_W = 12;
    localparam int DEF_LOST_W    = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;
endpackage

// File: rtl/selftrigger_readout_arbiter_if.sv
// Record port toward the waveform readout/framing engine (valid/ready).
interface selftrigger_readout_arbiter_if #(
    parameter int CH_W = 3,
    parameter int TS_W = 64
);
    logic            valid;
    logic            ready;
    logic [CH_W-1:0] ch;
    logic [TS_W-1:0] ts;

    modport master (output valid, ch, ts, input ready);
    modport slave  (input valid, ch, ts, output ready);
endinterface

// File: rtl/selftrigger_readout_arbiter_picker.sv
// Round-robin picker: first requesting channel after rr_ptr, wrapping.
module rr_priority_picker #(
    parameter int NUM_CH = 8,
    parameter int CH_W   = 3
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   rr_ptr,
    output logic [CH_W-1:0]   grant,
    output logic              any_valid
);
    int idx;

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (!any_valid && req[idx]) begin
                any_valid = 1'b1;
                grant     = CH_W'(idx);
            end
        end
    end
endmodule

// File: rtl/selftrigger_readout_arbiter.sv
// Self-trigger collector: edge detect, per-channel holdoff, timestamping,
// lost-trigger counting and round-robin arbitration onto one record port.
module selftrigger_readout_arbiter
    import selftrigger_readout_arbiter_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int CH_W      = $clog2(NUM_CH),
    parameter int TS_W      = DEF_TS_W,
    parameter int HOLDOFF_W = DEF_HOLDOFF_W,
    parameter int LOST_W    = DEF_LOST_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [NUM_CH-1:0]     ch_enable,
    input  logic [NUM_CH-1:0]     trig_in,
    input  logic [TS_W-1:0]       timestamp_in,
    input  logic [HOLDOFF_W-1:0]  holdoff,
    selftrigger_readout_arbiter_if.master rec,
    input  logic [CH_W-1:0]       lost_sel,
    output logic [LOST_W-1:0]     lost_count,
    input  logic                  lost_clr,
    output logic [NUM_CH-1:0]     pending
);
    logic [NUM_CH-1:0]              trig_q, trig_qq, edge_det, accept;
    logic [NUM_CH-1:0]              hold_zero, offered, hs;
    logic [TS_W-1:0]                ts_q;
    logic [NUM_CH-1:0][TS_W-1:0]    ts_pend;
    logic [NUM_CH-1:0][HOLDOFF_W-1:0] hold_cnt;
    logic [NUM_CH-1:0][LOST_W-1:0]  lost_cnt;
    state_t                         state, state_nxt;
    logic [CH_W-1:0]                rr_ptr, rec_ch_q, grant;
    logic [TS_W-1:0]                rec_ts_q;
    logic                           any_valid;

    // trig and timestamp sampled on the same edge so ts_q matches the first high sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_q  <= '0;
            trig_qq <= '0;
            ts_q    <= '0;
        end else begin
            trig_q  <= trig_in;
            trig_qq <= trig_q;
            ts_q    <= timestamp_in;
        end
    end

    assign edge_det = trig_q & ~trig_qq;
    assign accept   = edge_det & ch_enable & {NUM_CH{enable}} & hold_zero;

    always_comb begin
        hold_zero = '0;
        offered   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hold_zero[i] = (hold_cnt[i] == '0);
            offered[i]   = (state == ST_OFFER) && (rec_ch_q == CH_W'(i));
        end
        hs = offered & {NUM_CH{rec.ready}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            ts_pend  <= '0;
            hold_cnt <= '0;
            lost_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept[i])
                    hold_cnt[i] <= holdoff;
                else if (!hold_zero[i])
                    hold_cnt[i] <= hold_cnt[i] - HOLDOFF_W'(1);

                // a re-fire onto an undrained record keeps the original timestamp
                if (accept[i]) begin
                    pending[i] <= 1'b1;
                    if (!pending[i] || hs[i])
                        ts_pend[i] <= ts_q;
                end else if (hs[i] || (!ch_enable[i] && !offered[i])) begin
                    pending[i] <= 1'b0;
                end

                if (lost_clr)
                    lost_cnt[i] <= '0;
                else if (accept[i] && pending[i] && !hs[i] && (lost_cnt[i] != '1))
                    lost_cnt[i] <= lost_cnt[i] + LOST_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lost_count <= '0;
        else
            lost_count <= (int'(lost_sel) < NUM_CH) ? lost_cnt[lost_sel] : '0;
    end

    rr_priority_picker #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_picker (
        .req       (pending & ch_enable),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .any_valid (any_valid)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (any_valid) state_nxt = ST_OFFER;
            ST_OFFER: if (rec.ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= CH_W'(NUM_CH - 1);
            rec_ch_q <= '0;
            rec_ts_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && any_valid) begin
                rec_ch_q <= grant;
                rec_ts_q <= ts_pend[grant];
            end
            if (state == ST_OFFER && rec.ready)
                rr_ptr <= rec_ch_q;
        end
    end

    assign rec.valid = (state == ST_OFFER);
    assign rec.ch    = rec_ch_q;
    assign rec.ts    = rec_ts_q;
endmodule

// File: tb/tb_selftrigger_readout_arbiter.sv
// Scoreboard bench for selftrigger_readout_arbiter: expected records are queued
// when triggers are driven and compared at each handshake.
module tb_selftrigger_readout_arbiter;
    import selftrigger_readout_arbiter_pkg::*;

    localparam int NUM_CH    = 8;
    localparam int CH_W      = 3;
    localparam int TS_W      = 64;
    localparam int HOLDOFF_W = 12;
    // narrow lost counter keeps the saturation run short
    localparam int LOST_W    = 10;

    typedef struct {
        logic [CH_W-1:0] ch;
        logic [TS_W-1:0] ts;
    } rec_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 enable = 1'b1;
    logic [NUM_CH-1:0]    ch_enable = '1;
    logic [NUM_CH-1:0]    trig_in = '0;
    logic [TS_W-1:0]      tsc = '0;
    logic [HOLDOFF_W-1:0] holdoff = '0;
    logic                 rdy = 1'b0;
    logic [CH_W-1:0]      lost_sel = '0;
    logic [LOST_W-1:0]    lost_count;
    logic                 lost_clr = 1'b0;
    logic [NUM_CH-1:0]    pending;
    int                   cyc = 0;
    int                   checks = 0;
    int                   errors = 0;
    rec_t                 exp_q[$];
    int                   hs_cyc[$];
    rec_t                 mon_e;

    selftrigger_readout_arbiter_if #(.CH_W(CH_W), .TS_W(TS_W)) rec_if_i ();
    assign rec_if_i.ready = rdy;

    selftrigger_readout_arbiter #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .TS_W(TS_W),
        .HOLDOFF_W(HOLDOFF_W), .LOST_W(LOST_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .ch_enable    (ch_enable),
        .trig_in      (trig_in),
        .timestamp_in (tsc),
        .holdoff      (holdoff),
        .rec          (rec_if_i),
        .lost_sel     (lost_sel),
        .lost_count   (lost_count),
        .lost_clr     (lost_clr),
        .pending      (pending)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        tsc <= tsc + 64'd1;
        cyc <= cyc + 1;
    end

    // scoreboard: a handshake is due at the next rising edge
    always @(negedge clk) begin
        #1;
        if (reset_n && rec_if_i.valid && rdy) begin
            hs_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_record got ch=%0d ts=%0d, none expected", rec_if_i.ch, rec_if_i.ts);
            end else begin
                mon_e = exp_q.pop_front();
                if (rec_if_i.ch !== mon_e.ch || rec_if_i.ts !== mon_e.ts) begin
                    errors++;
                    $display("FAIL record got ch=%0d ts=%0d want ch=%0d ts=%0d",
                             rec_if_i.ch, rec_if_i.ts, mon_e.ch, mon_e.ts);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int ch, input logic [TS_W-1:0] ts);
        rec_t e;
        e.ch = CH_W'(ch);
        e.ts = ts;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        tick(2);
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if (rec_if_i.valid !== 1'b0 || pending !== '0 || lost_count !== '0 ||
            rec_if_i.ch !== '0 || rec_if_i.ts !== '0) begin
            errors++;
            $display("FAIL reset_state got valid=%b pending=%b lost=%0d ch=%0d ts=%0d want all 0",
                     rec_if_i.valid, pending, lost_count, rec_if_i.ch, rec_if_i.ts);
        end
        reset_n = 1'b1;
        tick(3);
        checks++;
        if (rec_if_i.valid !== 1'b0 || pending !== '0) begin
            errors++;
            $display("FAIL idle_after_reset got valid=%b pending=%b want 0", rec_if_i.valid, pending);
        end
    endtask

    task automatic test_round_robin();
        holdoff = '0;
        rdy = 1'b1;
        hs_cyc.delete();
        push_exp(0, tsc); push_exp(2, tsc); push_exp(5, tsc);
        trig_in = 8'b0010_0101;
        tick(1);
        trig_in = '0;
        wait_drain(40);
        checks++;
        if (exp_q.size() != 0 || hs_cyc.size() != 3) begin
            errors++;
            $display("FAIL rr_drain got left=%0d handshakes=%0d want 0 and 3", exp_q.size(), hs_cyc.size());
            exp_q.delete();
        end else begin
            checks++;
            if (hs_cyc[1] - hs_cyc[0] != 2 || hs_cyc[2] - hs_cyc[1] != 2) begin
                errors++;
                $display("FAIL rr_spacing got %0d,%0d want 2,2", hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1]);
            end
        end
        // move the pointer to channel 2, then the same burst should start at 5
        push_exp(2, tsc);
        trig_in[2] = 1'b1;
        tick(1);
        trig_in = '0;
        wait_drain(20);
        push_exp(5, tsc); push_exp(0, tsc); push_exp(2, tsc);
        trig_in = 8'b0010_0101;
        tick(1);
        trig_in = '0;
        wait_drain(40);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_ptr2_drain got left=%0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_single();
        holdoff = 12'd10;
        rdy = 1'b1;
        while (tsc < 64'd100) @(negedge clk);
        push_exp(3, tsc);
        trig_in[3] = 1'b1;
        tick(5);
        trig_in[3] = 1'b0;
        wait_drain(30);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_drain got left=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        lost_sel = 3'd3;
        tick(2);
        checks++;
        if (lost_count !== '0) begin
            errors++;
            $display("FAIL single_lost got %0d want 0", lost_count);
        end
    endtask

    task automatic test_holdoff();
        holdoff = 12'd20;
        rdy = 1'b0;
        lost_sel = 3'd1;
        tick(2);
        push_exp(1, tsc);
        trig_in[1] = 1'b1;
        tick(1);
        trig_in[1] = 1'b0;
        tick(7);
        trig_in[1] = 1'b1;
        tick(1);
        trig_in[1] = 1'b0;
        tick(7);
        checks++;
        if (lost_count !== '0) begin
            errors++;
            $display("FAIL holdoff_suppressed got lost=%0d want 0", lost_count);
        end
        tick(9);
        trig_in[1] = 1'b1;
        tick(1);
        trig_in[1] = 1'b0;
        tick(3);
        checks++;
        if (lost_count !== LOST_W'(1)) begin
            errors++;
            $display("FAIL holdoff_lost got lost=%0d want 1", lost_count);
        end
        rdy = 1'b1;
        wait_drain(20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL holdoff_drain got left=%0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_handshake_collision();
        holdoff = '0;
        rdy = 1'b0;
        lost_sel = 3'd4;
        tick(2);
        push_exp(4, tsc);
        trig_in[4] = 1'b1;
        tick(1);
        trig_in[4] = 1'b0;
        tick(2);
        checks++;
        if (rec_if_i.valid !== 1'b1 || rec_if_i.ch !== 3'd4) begin
            errors++;
            $display("FAIL collide_offer got valid=%b ch=%0d want 1 and 4", rec_if_i.valid, rec_if_i.ch);
        end
        push_exp(4, tsc);
        trig_in[4] = 1'b1;
        tick(1);
        rdy = 1'b1;
        trig_in[4] = 1'b0;
        tick(1);
        checks++;
        if (pending[4] !== 1'b1) begin
            errors++;
            $display("FAIL collide_pending got %b want 1", pending[4]);
        end
        wait_drain(20);
        checks++;
        if (exp_q.size() != 0 || lost_count !== '0) begin
            errors++;
            $display("FAIL collide_drain got left=%0d lost=%0d want 0 and 0", exp_q.size(), lost_count);
            exp_q.delete();
        end
    endtask

    task automatic test_lost_saturation();
        holdoff = '0;
        rdy = 1'b0;
        lost_sel = 3'd7;
        tick(2);
        push_exp(7, tsc);
        trig_in[7] = 1'b1;
        tick(1);
        trig_in[7] = 1'b0;
        tick(1);
        for (int i = 0; i < (1 << LOST_W) + 20; i++) begin
            trig_in[7] = 1'b1;
            tick(1);
            trig_in[7] = 1'b0;
            tick(1);
        end
        tick(3);
        checks++;
        if (lost_count !== {LOST_W{1'b1}}) begin
            errors++;
            $display("FAIL lost_saturate got %0d want %0d", lost_count, (1 << LOST_W) - 1);
        end
        // clear lands on the same edge as another lost event
        trig_in[7] = 1'b1;
        tick(1);
        lost_clr = 1'b1;
        trig_in[7] = 1'b0;
        tick(1);
        lost_clr = 1'b0;
        tick(1);
        checks++;
        if (lost_count !== '0) begin
            errors++;
            $display("FAIL lost_clear got %0d want 0", lost_count);
        end
        trig_in[7] = 1'b1;
        tick(1);
        trig_in[7] = 1'b0;
        tick(3);
        checks++;
        if (lost_count !== LOST_W'(1)) begin
            errors++;
            $display("FAIL lost_after_clear got %0d want 1", lost_count);
        end
        rdy = 1'b1;
        wait_drain(20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL lost_drain got left=%0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_offer();
        int n = 0;
        holdoff = '0;
        rdy = 1'b0;
        tick(2);
        trig_in[6] = 1'b1;
        tick(1);
        trig_in[6] = 1'b0;
        while (rec_if_i.valid !== 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        checks++;
        if (rec_if_i.valid !== 1'b1) begin
            errors++;
            $display("FAIL midoffer_valid got %b want 1", rec_if_i.valid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (rec_if_i.valid !== 1'b0 || pending !== '0) begin
            errors++;
            $display("FAIL midoffer_async got valid=%b pending=%b want 0", rec_if_i.valid, pending);
        end
        tick(1);
        reset_n = 1'b1;
        rdy = 1'b1;
        tick(10);
        checks++;
        if (rec_if_i.valid !== 1'b0 || pending !== '0) begin
            errors++;
            $display("FAIL midoffer_quiet got valid=%b pending=%b want 0", rec_if_i.valid, pending);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_holdoff();
        test_handshake_collision();
        test_lost_saturation();
        test_reset_mid_offer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
